// File: rtl/lcd_pixel_pair_packer.sv
// Packs a single-lane 24-bit pixel stream into 48-bit pixel pairs for a dual-lane LVDS FIFO.
// Odd-length lines are padded with PAD_DATA and flagged; line length is measured per line.
module lcd_pixel_pair_packer #(
  parameter logic [23:0] PAD_DATA = 24'h000000,
  parameter int          LEN_W    = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vs_i,
  input  logic             hs_i,
  input  logic             de_i,
  input  logic [23:0]      data_i,
  output logic             vs_o,
  output logic             hs_o,
  output logic             de_o,
  output logic [47:0]      data_o,
  output logic [LEN_W-1:0] line_len_o,
  output logic             odd_err_o
);

  typedef enum logic {EVEN, ODD} state_t;

  state_t           state, state_nxt;
  logic [23:0]      hold, hold_nxt;
  logic [47:0]      pair;
  logic             emit, pad_emit;
  logic             de_d;
  logic [LEN_W-1:0] line_cnt;
  logic             vs_rise, de_fall;

  // vs_o doubles as the previous vs_i sample; it is 0 after reset
  assign vs_rise = vs_i & ~vs_o;
  assign de_fall = ~de_i & de_d;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    pair      = data_o;
    emit      = 1'b0;
    pad_emit  = 1'b0;
    if (vs_rise) begin
      // Frame start drops any held pixel; a coincident pixel starts a fresh pair
      state_nxt = EVEN;
      if (de_i) begin
        hold_nxt  = data_i;
        state_nxt = ODD;
      end
    end else begin
      case (state)
        EVEN: begin
          if (de_i) begin
            hold_nxt  = data_i;
            state_nxt = ODD;
          end
        end
        ODD: begin
          emit      = 1'b1;
          state_nxt = EVEN;
          if (de_i) begin
            pair = {data_i, hold};
          end else begin
            pair     = {PAD_DATA, hold};
            pad_emit = 1'b1;
          end
        end
        default: state_nxt = EVEN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= EVEN;
      hold      <= '0;
      data_o    <= '0;
      de_o      <= 1'b0;
      vs_o      <= 1'b0;
      hs_o      <= 1'b0;
      de_d      <= 1'b0;
      odd_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      de_o  <= emit;
      vs_o  <= vs_i;
      hs_o  <= hs_i;
      de_d  <= de_i;
      if (emit) data_o <= pair;
      if (pad_emit) odd_err_o <= 1'b1;
    end
  end

  // Saturating per-line pixel counter, published when de_i drops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_cnt   <= '0;
      line_len_o <= '0;
    end else if (vs_rise) begin
      line_cnt <= {{(LEN_W-1){1'b0}}, de_i};
    end else if (de_fall) begin
      line_len_o <= line_cnt;
      line_cnt   <= '0;
    end else if (de_i && (line_cnt != {LEN_W{1'b1}})) begin
      line_cnt <= line_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_lcd_pixel_pair_packer.sv
// Directed self-checking bench for lcd_pixel_pair_packer (LEN_W=4 so saturation is reachable).
module tb_lcd_pixel_pair_packer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
  logic [23:0] data_i = '0;
  logic        vs_o, hs_o, de_o, odd_err_o;
  logic [47:0] data_o;
  logic [3:0]  line_len_o;

  int vectors = 0;
  int miscompares = 0;
  int pairs = 0;

  lcd_pixel_pair_packer #(.PAD_DATA(24'h000000), .LEN_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
    .data_i(data_i), .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
    .line_len_o(line_len_o), .odd_err_o(odd_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives one cycle of inputs, then waits until just after the capturing edge
  task automatic applyStimulus(input logic rst, input logic vs, input logic hs,
                               input logic de, input logic [23:0] d);
    rst_i  = rst;
    vs_i   = vs;
    hs_i   = hs;
    de_i   = de;
    data_i = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #1;
    // Reset state
    applyStimulus(1, 1, 1, 0, 24'h0);
    applyStimulus(1, 0, 1, 0, 24'h0);
    checkOutput("rst_de_o", de_o, 0);
    checkOutput("rst_data_o", data_o, 0);
    checkOutput("rst_line_len", line_len_o, 0);
    checkOutput("rst_odd_err", odd_err_o, 0);
    checkOutput("rst_vs_o", vs_o, 0);
    checkOutput("rst_hs_o", hs_o, 0);

    // Sync passthrough across reset release
    applyStimulus(0, 0, 1, 0, 24'h0);
    checkOutput("sync_hs_hi", hs_o, 1);
    checkOutput("sync_vs_lo", vs_o, 0);
    applyStimulus(0, 1, 0, 0, 24'h0);
    checkOutput("sync_vs_hi", vs_o, 1);
    checkOutput("sync_hs_lo", hs_o, 0);
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("sync_vs_back", vs_o, 0);

    // Even line of four pixels
    applyStimulus(0, 0, 0, 1, 24'h000001);
    checkOutput("even_p1_de", de_o, 0);
    applyStimulus(0, 0, 0, 1, 24'h000002);
    checkOutput("even_p2_de", de_o, 1);
    checkOutput("even_pair1", data_o, 48'h000002_000001);
    applyStimulus(0, 0, 0, 1, 24'h000003);
    checkOutput("even_p3_de", de_o, 0);
    checkOutput("even_hold_data", data_o, 48'h000002_000001);
    applyStimulus(0, 0, 0, 1, 24'h000004);
    checkOutput("even_p4_de", de_o, 1);
    checkOutput("even_pair2", data_o, 48'h000004_000003);
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("even_end_de", de_o, 0);
    checkOutput("even_line_len", line_len_o, 4);
    checkOutput("even_odd_err", odd_err_o, 0);

    // Odd line of three pixels, padded pair, sticky error across vs pulse
    applyStimulus(0, 0, 0, 1, 24'hAAAAAA);
    checkOutput("odd_p1_de", de_o, 0);
    applyStimulus(0, 0, 0, 1, 24'hBBBBBB);
    checkOutput("odd_pair1", data_o, 48'hBBBBBB_AAAAAA);
    applyStimulus(0, 0, 0, 1, 24'hCCCCCC);
    checkOutput("odd_p3_de", de_o, 0);
    checkOutput("odd_err_before_pad", odd_err_o, 0);
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("odd_pad_de", de_o, 1);
    checkOutput("odd_pad_pair", data_o, 48'h000000_CCCCCC);
    checkOutput("odd_err_set", odd_err_o, 1);
    checkOutput("odd_line_len", line_len_o, 3);
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("odd_strobe_once", de_o, 0);
    applyStimulus(0, 1, 0, 0, 24'h0);
    checkOutput("odd_err_vs_hi", odd_err_o, 1);
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("odd_err_vs_lo", odd_err_o, 1);
    checkOutput("odd_len_kept_vs", line_len_o, 3);

    // Frame restart with a pixel coincident with the vs edge
    applyStimulus(0, 0, 0, 1, 24'h123456);
    checkOutput("restart_p1_de", de_o, 0);
    applyStimulus(0, 1, 0, 1, 24'h654321);
    checkOutput("restart_vs_de", de_o, 0);
    applyStimulus(0, 1, 0, 1, 24'h111111);
    checkOutput("restart_pair_de", de_o, 1);
    checkOutput("restart_pair", data_o, 48'h111111_654321);
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("restart_end_de", de_o, 0);
    checkOutput("restart_line_len", line_len_o, 2);

    // Saturation: 20 pixels with a 4-bit counter
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(0, 0, 0, 1, 24'(k));
      if (de_o) pairs++;
      checkOutput($sformatf("sat_de_%0d", k), de_o, 64'((k % 2) == 0));
    end
    checkOutput("sat_last_pair", data_o, {24'd20, 24'd19});
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("sat_end_de", de_o, 0);
    checkOutput("sat_pairs", pairs, 10);
    checkOutput("sat_line_len", line_len_o, 15);

    // Reset mid-line: held pixel discarded, no padded pair afterwards
    applyStimulus(0, 0, 0, 1, 24'h777777);
    checkOutput("midrst_hold_de", de_o, 0);
    applyStimulus(1, 1, 1, 0, 24'h0);
    checkOutput("midrst_de", de_o, 0);
    checkOutput("midrst_data", data_o, 0);
    checkOutput("midrst_len", line_len_o, 0);
    checkOutput("midrst_err", odd_err_o, 0);
    checkOutput("midrst_vs", vs_o, 0);
    checkOutput("midrst_hs", hs_o, 0);
    applyStimulus(0, 1, 1, 0, 24'h0);
    checkOutput("postrst_de", de_o, 0);
    checkOutput("postrst_vs", vs_o, 1);
    checkOutput("postrst_hs", hs_o, 1);
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("postrst_de2", de_o, 0);
    checkOutput("postrst_err", odd_err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_pair_packer.md
LCD_PIXEL_PAIR_PACKER -- requirements
Module: lcd_pixel_pair_packer

Interface
REQ-001 Parameter PAD_DATA, default 24'h000000: pixel value placed in the upper lane when a line has an odd pixel count.
REQ-002 Parameter LEN_W, default 12: width of the line-length counter.
REQ-003 clk_i  input  1  single clock for all logic; pixel clock of the incoming single-lane stream.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 vs_i  input  1  vertical sync, active-high; a rising edge marks frame start.
REQ-006 hs_i  input  1  horizontal sync, passed through.
REQ-007 de_i  input  1  data enable; one pixel per cycle while high.
REQ-008 data_i  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-009 vs_o  output  1  vs_i delayed 1 cycle.
REQ-010 hs_o  output  1  hs_i delayed 1 cycle.
REQ-011 de_o  output  1  one-cycle strobe; data_o holds a valid pixel pair.
REQ-012 data_o  output  48  pixel pair {second pixel[47:24], first pixel[23:0]}; feeds the dual-lane LVDS FIFO write port.
REQ-013 line_len_o  output  LEN_W  pixel count of the most recently completed line.
REQ-014 odd_err_o  output  1  sticky flag, set when any line had an odd pixel count.

Function
REQ-015 Two-state FSM: EVEN (no pixel held) and ODD (first pixel of a pair held in a 24-bit register).
REQ-016 EVEN with de_i=1: latch data_i into the hold register; go to ODD; de_o=0 next cycle.
REQ-017 ODD with de_i=1: on the next cycle, data_o={data_i, hold} and de_o=1; go to EVEN.
REQ-018 Output latency: de_o is asserted 1 cycle after the cycle in which the second pixel of a pair is presented.
REQ-019 de_o is a single-cycle strobe; it is never high on two consecutive cycles.
REQ-020 data_o holds its last value while de_o=0.
REQ-021 ODD with de_i=0 (line ends on an odd pixel): on the next cycle, data_o={PAD_DATA, hold}, de_o=1, and odd_err_o is set; go to EVEN.
REQ-022 vs_i rising edge (vs_i=1, previous vs_i=0): force EVEN and discard any held pixel with no de_o for it.
REQ-023 If de_i=1 in the same cycle as a vs_i rising edge, the vs edge is applied first; the current pixel is then latched as a new first pixel (state ODD).
REQ-024 odd_err_o is cleared only by rst_i; it is not cleared by vs_i.
REQ-025 Line counter: increments on each cycle with de_i=1.
REQ-026 Line counter saturates at 2^LEN_W-1.
REQ-027 On a de_i falling edge, the line counter value (including the last pixel) is copied to line_len_o on the next cycle, and the counter is cleared.
REQ-028 A vs_i rising edge clears the line counter; line_len_o is unchanged.
REQ-029 vs_o and hs_o are the 1-cycle registered copies of vs_i and hs_i, independent of the FSM.

Reset
REQ-030 On a clk_i edge with rst_i=1: FSM=EVEN, hold=0, data_o=0, de_o=0, vs_o=0, hs_o=0, line counter=0, line_len_o=0, odd_err_o=0.
REQ-031 Reset asserted mid-line: the held pixel is discarded and no padded pair is emitted.
REQ-032 The first cycle after reset deasserts behaves as EVEN with no previous vs_i (previous vs_i=0).

Verification
REQ-033 Even line: de_i high for 4 cycles with pixels 0x000001..0x000004 -> de_o pulses twice, data_o=0x000002_000001 then 0x000004_000003; line_len_o=4; odd_err_o=0.
REQ-034 Odd line: 3 pixels 0xAAAAAA, 0xBBBBBB, 0xCCCCCC -> pairs 0xBBBBBB_AAAAAA, then 0x000000_CCCCCC one cycle after de_i falls; odd_err_o=1 and stays 1 across a following vs_i pulse.
REQ-035 Frame restart: one pixel 0x123456 held, then a vs_i rising edge together with de_i=1 and pixel 0x654321, then pixel 0x111111 -> no output for 0x123456; next pair=0x111111_654321.
REQ-036 Saturation: with LEN_W=4, de_i high for 20 cycles -> line_len_o=15; 10 pairs emitted.
REQ-037 Reset mid-line: 1 pixel held, rst_i pulsed for 1 cycle -> de_o stays 0; all outputs 0.
REQ-038 Sync passthrough: a vs_i/hs_i pattern appears on vs_o/hs_o delayed by exactly 1 cycle, including during reset release.
